// File: rtl/node.sv
// In-network reduction node: forwards +X/+Y traffic and combines flits of
// programmed communicators (sum/max/min) into one result flit per round.
module node (
  input  logic        clk,
  input  logic        rst,
  input  logic [84:0] inject_xpos,
  input  logic [84:0] inject_ypos,
  input  logic [81:0] in_xpos_ser,
  input  logic [81:0] in_ypos_ser,
  input  logic [60:0] newcomm,
  output logic [81:0] out_xpos_ser,
  output logic [81:0] out_ypos_ser
);
  localparam int         DATA_W = 64;
  localparam int         NENT   = 4;
  localparam logic [2:0] OP_SUM = 3'b001;
  localparam logic [2:0] OP_MAX = 3'b010;
  localparam logic [2:0] OP_MIN = 3'b011;

  function automatic logic is_reduce(input logic [2:0] op);
    return (op == OP_SUM) || (op == OP_MAX) || (op == OP_MIN);
  endfunction

  function automatic logic [DATA_W-1:0] combine(input logic [2:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      OP_SUM:  r = a + b;
      OP_MAX:  r = (a > b) ? a : b;
      default: r = (a < b) ? a : b;
    endcase
    return r;
  endfunction

  logic [NENT-1:0]   vld_q, vld_d;
  logic [7:0]        cid_q   [NENT];
  logic [7:0]        cid_d   [NENT];
  logic [2:0]        op_q    [NENT];
  logic [2:0]        op_d    [NENT];
  logic [3:0]        fanin_q [NENT];
  logic [3:0]        fanin_d [NENT];
  logic [8:0]        tag_q   [NENT];
  logic [8:0]        tag_d   [NENT];
  logic [1:0]        mask_q  [NENT];
  logic [1:0]        mask_d  [NENT];
  logic [DATA_W-1:0] acc_q   [NENT];
  logic [DATA_W-1:0] acc_d   [NENT];
  logic [2:0]        cnt_q   [NENT];
  logic [2:0]        cnt_d   [NENT];
  logic [DATA_W-1:0] res_q   [NENT];
  logic [DATA_W-1:0] res_d   [NENT];
  // Pending result, one bit per output still owed: [0] = +X, [1] = +Y.
  logic [1:0]        rem_q   [NENT];
  logic [1:0]        rem_d   [NENT];
  logic [81:0]       outx_q, outx_d, outy_q, outy_d;

  logic [81:0] src [4];
  logic [3:0]  src_byp;
  logic [3:0]  hit;
  logic [1:0]  fwd, byp;
  logic        wr;
  logic [1:0]  wr_idx;
  logic        unused_bits;

  assign src[0]  = inject_xpos[81:0];
  assign src[1]  = inject_ypos[81:0];
  assign src[2]  = in_xpos_ser;
  assign src[3]  = in_ypos_ser;
  assign src_byp = {2'b00, inject_ypos[84], inject_xpos[84]};
  assign wr      = newcomm[60];
  assign wr_idx  = newcomm[53:52];
  assign unused_bits = ^{inject_xpos[83:82], inject_ypos[83:82], newcomm[51:34],
                         newcomm[17:11], newcomm[8:0]};

  always_comb begin : classify
    logic [1:0] idx;
    hit = '0;
    for (int s = 0; s < 4; s++) begin
      idx    = src[s][74:73];
      hit[s] = src[s][81] && !src_byp[s] && vld_q[idx] &&
               (cid_q[idx] == src[s][80:73]) && is_reduce(op_q[idx]);
    end
    byp[0] = inject_xpos[84] && inject_xpos[81];
    byp[1] = inject_ypos[84] && inject_ypos[81];
    fwd[0] = in_xpos_ser[81] && !hit[2];
    fwd[1] = in_ypos_ser[81] && !hit[3];
  end

  always_comb begin : update
    logic              have;
    logic [DATA_W-1:0] val;
    logic [2:0]        n;
    logic [3:0]        total;
    logic [3:0]        fin;
    logic              wr_hit;
    logic              found_x, found_y;
    vld_d = vld_q;
    for (int e = 0; e < NENT; e++) begin
      cid_d[e]   = cid_q[e];
      op_d[e]    = op_q[e];
      fanin_d[e] = fanin_q[e];
      tag_d[e]   = tag_q[e];
      mask_d[e]  = mask_q[e];
      acc_d[e]   = acc_q[e];
      cnt_d[e]   = cnt_q[e];
      res_d[e]   = res_q[e];
      rem_d[e]   = rem_q[e];
      have = (cnt_q[e] != 3'd0);
      val  = acc_q[e];
      n    = 3'd0;
      for (int s = 0; s < 4; s++) begin
        if (hit[s] && (src[s][74:73] == 2'(e))) begin
          val  = have ? combine(op_q[e], val, src[s][63:0]) : src[s][63:0];
          have = 1'b1;
          n    = n + 3'd1;
        end
      end
      total  = {1'b0, cnt_q[e]} + {1'b0, n};
      fin    = (fanin_q[e] == 4'd0) ? 4'd1 : fanin_q[e];
      wr_hit = wr && (wr_idx == 2'(e));
      if (!wr_hit && (n != 3'd0)) begin
        if (total >= fin) begin
          acc_d[e] = '0;
          cnt_d[e] = 3'd0;
          res_d[e] = val;
          rem_d[e] = mask_q[e];
        end else begin
          acc_d[e] = val;
          cnt_d[e] = total[2:0];
        end
      end
    end

    // A result completing this cycle competes for the output immediately.
    outx_d  = fwd[0] ? in_xpos_ser : (byp[0] ? inject_xpos[81:0] : '0);
    outy_d  = fwd[1] ? in_ypos_ser : (byp[1] ? inject_ypos[81:0] : '0);
    found_x = fwd[0] || byp[0];
    found_y = fwd[1] || byp[1];
    for (int e = 0; e < NENT; e++) begin
      if (!found_x && rem_d[e][0]) begin
        outx_d      = {1'b1, cid_q[e], tag_q[e], res_d[e]};
        rem_d[e][0] = 1'b0;
        found_x     = 1'b1;
      end
      if (!found_y && rem_d[e][1]) begin
        outy_d      = {1'b1, cid_q[e], tag_q[e], res_d[e]};
        rem_d[e][1] = 1'b0;
        found_y     = 1'b1;
      end
    end

    for (int e = 0; e < NENT; e++) begin
      if (wr && (wr_idx == 2'(e))) begin
        vld_d[e]   = 1'b1;
        cid_d[e]   = newcomm[59:52];
        op_d[e]    = newcomm[33:31];
        fanin_d[e] = newcomm[30:27];
        tag_d[e]   = newcomm[26:18];
        mask_d[e]  = {newcomm[10], newcomm[9]};
        acc_d[e]   = '0;
        cnt_d[e]   = 3'd0;
        rem_d[e]   = 2'b00;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      outx_q <= '0;
      outy_q <= '0;
      for (int e = 0; e < NENT; e++) begin
        cid_q[e]   <= '0;
        op_q[e]    <= '0;
        fanin_q[e] <= '0;
        tag_q[e]   <= '0;
        mask_q[e]  <= '0;
        acc_q[e]   <= '0;
        cnt_q[e]   <= '0;
        res_q[e]   <= '0;
        rem_q[e]   <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      outx_q <= outx_d;
      outy_q <= outy_d;
      for (int e = 0; e < NENT; e++) begin
        cid_q[e]   <= cid_d[e];
        op_q[e]    <= op_d[e];
        fanin_q[e] <= fanin_d[e];
        tag_q[e]   <= tag_d[e];
        mask_q[e]  <= mask_d[e];
        acc_q[e]   <= acc_d[e];
        cnt_q[e]   <= cnt_d[e];
        res_q[e]   <= res_d[e];
        rem_q[e]   <= rem_d[e];
      end
    end
  end

  assign out_xpos_ser = outx_q;
  assign out_ypos_ser = outy_q;
endmodule

// File: tb/tb_node.sv
// Bench for the reduction node: directed scenarios plus a randomized run
// against a list-based reference model of the communicator table.
module tb_node;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [84:0] inject_xpos = '0;
  logic [84:0] inject_ypos = '0;
  logic [81:0] in_xpos_ser = '0;
  logic [81:0] in_ypos_ser = '0;
  logic [60:0] newcomm = '0;
  logic [81:0] out_xpos_ser, out_ypos_ser;
  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0]  SUM  = 3'b001;
  localparam logic [2:0]  MAX  = 3'b010;
  localparam logic [2:0]  MIN  = 3'b011;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  node dut (
    .clk(clk), .rst(rst),
    .inject_xpos(inject_xpos), .inject_ypos(inject_ypos),
    .in_xpos_ser(in_xpos_ser), .in_ypos_ser(in_ypos_ser),
    .newcomm(newcomm),
    .out_xpos_ser(out_xpos_ser), .out_ypos_ser(out_ypos_ser)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [81:0] mk(input logic [7:0] cid, input logic [8:0] tag,
                                     input logic [63:0] pay);
    return {1'b1, cid, tag, pay};
  endfunction

  function automatic logic [60:0] nc(input logic [7:0] cid, input logic [2:0] op,
                                     input logic [3:0] fanin, input logic [8:0] tag,
                                     input logic [1:0] mask);
    return {1'b1, cid, 18'd0, op, fanin, tag, 7'd0, mask[1], mask[0], 9'd0};
  endfunction

  function automatic logic [84:0] inj(input logic byp, input logic [81:0] f);
    return {byp, 2'b00, f};
  endfunction

  task automatic idle();
    inject_xpos = '0; inject_ypos = '0;
    in_xpos_ser = '0; in_ypos_ser = '0;
    newcomm     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic program_comm(input logic [7:0] cid, input logic [2:0] op,
                              input logic [3:0] fanin, input logic [8:0] tag,
                              input logic [1:0] mask);
    newcomm = nc(cid, op, fanin, tag, mask);
    tick();
    newcomm = '0;
  endtask

  // ---------------- reference model ----------------
  logic        mv    [4];
  logic [7:0]  mcid  [4];
  logic [2:0]  mop   [4];
  logic [3:0]  mfan  [4];
  logic [8:0]  mtag  [4];
  logic [1:0]  mmask [4];
  logic [63:0] mparts[4][$];
  logic [81:0] mres  [4];
  logic [1:0]  mrem  [4];

  task automatic model_clear();
    for (int e = 0; e < 4; e++) begin
      mv[e] = 1'b0; mcid[e] = '0; mop[e] = '0; mfan[e] = '0; mtag[e] = '0;
      mmask[e] = '0; mres[e] = '0; mrem[e] = '0;
      mparts[e].delete();
    end
  endtask

  task automatic model_step(output logic [81:0] ex, output logic [81:0] ey);
    logic [81:0] f [4];
    logic [81:0] outv [2];
    logic [1:0]  fwd, byp;
    logic        m, wr, bp;
    int          e, wi, fin;
    logic [63:0] v;
    f[0] = inject_xpos[81:0]; f[1] = inject_ypos[81:0];
    f[2] = in_xpos_ser;       f[3] = in_ypos_ser;
    fwd = '0; byp = '0;
    wr  = newcomm[60];
    wi  = int'(newcomm[53:52]);
    for (int s = 0; s < 4; s++) begin
      e  = int'(f[s][74:73]);
      m  = f[s][81] && mv[e] && (mcid[e] == f[s][80:73]) && (mop[e] inside {SUM, MAX, MIN});
      bp = (s == 0) ? inject_xpos[84] : ((s == 1) ? inject_ypos[84] : 1'b0);
      if (bp) begin
        if (f[s][81]) byp[s] = 1'b1;
      end else if (m) begin
        if (!(wr && wi == e)) mparts[e].push_back(f[s][63:0]);
      end else if (s >= 2 && f[s][81]) begin
        fwd[s-2] = 1'b1;
      end
    end
    for (int k = 0; k < 4; k++) begin
      fin = (mfan[k] == 4'd0) ? 1 : int'(mfan[k]);
      if (mparts[k].size() >= fin) begin
        v = mparts[k][0];
        for (int i = 1; i < mparts[k].size(); i++) begin
          if (mop[k] == SUM) v = v + mparts[k][i];
          else if (mop[k] == MAX) v = (mparts[k][i] > v) ? mparts[k][i] : v;
          else v = (mparts[k][i] < v) ? mparts[k][i] : v;
        end
        mres[k] = {1'b1, mcid[k], mtag[k], v};
        mrem[k] = mmask[k];
        mparts[k].delete();
      end
    end
    for (int o = 0; o < 2; o++) begin
      outv[o] = '0;
      if (fwd[o]) outv[o] = f[o+2];
      else if (byp[o]) outv[o] = f[o];
      else begin
        for (int k = 0; k < 4; k++) begin
          if (mrem[k][o]) begin
            outv[o] = mres[k];
            mrem[k][o] = 1'b0;
            break;
          end
        end
      end
    end
    if (wr) begin
      mv[wi] = 1'b1; mcid[wi] = newcomm[59:52]; mop[wi] = newcomm[33:31];
      mfan[wi] = newcomm[30:27]; mtag[wi] = newcomm[26:18];
      mmask[wi] = {newcomm[10], newcomm[9]};
      mparts[wi].delete();
      mrem[wi] = 2'b00;
    end
    ex = outv[0];
    ey = outv[1];
  endtask

  function automatic logic [7:0] rcid();
    case ($urandom_range(0, 5))
      0: return 8'h01;
      1: return 8'h02;
      2: return 8'h05;
      3: return 8'h83;
      4: return 8'h40;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [81:0] rflit();
    logic [63:0] pay;
    case ($urandom_range(0, 3))
      0: pay = ONES;
      1: pay = 64'($urandom_range(0, 15));
      default: pay = {$urandom, $urandom};
    endcase
    return {1'($urandom_range(0, 1)), rcid(), 9'($urandom), pay};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle(); rst = 1'b0; #2;
    n_checks++; if (out_xpos_ser !== 82'd0) begin n_fail++; $display("FAIL reset_x: got %h want 0", out_xpos_ser); end
    n_checks++; if (out_ypos_ser !== 82'd0) begin n_fail++; $display("FAIL reset_y: got %h want 0", out_ypos_ser); end
    newcomm = nc(8'h01, SUM, 4'd1, 9'd1, 2'b01);
    in_xpos_ser = mk(8'h01, 9'd0, 64'd6);
    tick();
    n_checks++; if (out_xpos_ser !== 82'd0) begin n_fail++; $display("FAIL reset_hold_x: got %h want 0", out_xpos_ser); end
    newcomm = '0;
    rst = 1'b1;
    tick();
    n_checks++; if (out_xpos_ser !== mk(8'h01, 9'd0, 64'd6)) begin n_fail++; $display("FAIL reset_nc_ignored: got %h want %h", out_xpos_ser, mk(8'h01, 9'd0, 64'd6)); end
    idle(); tick();
    n_checks++; if (out_xpos_ser !== 82'd0) begin n_fail++; $display("FAIL reset_idle_x: got %h want 0", out_xpos_ser); end
  endtask

  task automatic test_passthrough();
    do_reset();
    in_xpos_ser = mk(8'h05, 9'd0, 64'd6);
    tick();
    n_checks++; if (out_xpos_ser !== mk(8'h05, 9'd0, 64'd6)) begin n_fail++; $display("FAIL pass_x: got %h want %h", out_xpos_ser, mk(8'h05, 9'd0, 64'd6)); end
    n_checks++; if (out_ypos_ser !== 82'd0) begin n_fail++; $display("FAIL pass_y: got %h want 0", out_ypos_ser); end
    idle(); tick();
    n_checks++; if (out_xpos_ser !== 82'd0) begin n_fail++; $display("FAIL pass_after: got %h want 0", out_xpos_ser); end
  endtask

  task automatic test_sum();
    logic [63:0] pays [3] = '{64'd6, 64'd5, 64'd4};
    do_reset();
    program_comm(8'h01, SUM, 4'd3, 9'd9, 2'b01);
    for (int i = 0; i < 3; i++) begin
      in_xpos_ser = mk(8'h01, 9'd0, pays[i]);
      tick();
      if (i < 2) begin
        n_checks++; if (out_xpos_ser !== 82'd0) begin n_fail++; $display("FAIL sum_partial%0d: got %h want 0", i, out_xpos_ser); end
      end
    end
    n_checks++; if (out_xpos_ser !== mk(8'h01, 9'd9, 64'd15)) begin n_fail++; $display("FAIL sum_result: got %h want %h", out_xpos_ser, mk(8'h01, 9'd9, 64'd15)); end
    n_checks++; if (out_ypos_ser !== 82'd0) begin n_fail++; $display("FAIL sum_y: got %h want 0", out_ypos_ser); end
    idle(); tick();
    n_checks++; if (out_xpos_ser !== 82'd0) begin n_fail++; $display("FAIL sum_once: got %h want 0", out_xpos_ser); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    program_comm(8'h02, MAX, 4'd4, 9'd7, 2'b11);
    inject_xpos = inj(1'b0, mk(8'h02, 9'd0, 64'd3));
    inject_ypos = inj(1'b0, mk(8'h02, 9'd0, 64'd9));
    in_xpos_ser = mk(8'h02, 9'd0, 64'd2);
    in_ypos_ser = mk(8'h02, 9'd0, 64'd7);
    tick();
    n_checks++; if (out_xpos_ser !== mk(8'h02, 9'd7, 64'd9)) begin n_fail++; $display("FAIL max4_x: got %h want %h", out_xpos_ser, mk(8'h02, 9'd7, 64'd9)); end
    n_checks++; if (out_ypos_ser !== mk(8'h02, 9'd7, 64'd9)) begin n_fail++; $display("FAIL max4_y: got %h want %h", out_ypos_ser, mk(8'h02, 9'd7, 64'd9)); end
    idle(); tick();
    n_checks++; if ({out_xpos_ser, out_ypos_ser} !== 164'd0) begin n_fail++; $display("FAIL max4_after: got %h %h want 0 0", out_xpos_ser, out_ypos_ser); end
  endtask

  task automatic test_conflict();
    do_reset();
    program_comm(8'h03, SUM, 4'd1, 9'd5, 2'b01);
    inject_xpos = inj(1'b0, mk(8'h03, 9'd0, 64'd42));
    in_xpos_ser = mk(8'h44, 9'd1, 64'd77);
    tick();
    n_checks++; if (out_xpos_ser !== mk(8'h44, 9'd1, 64'd77)) begin n_fail++; $display("FAIL conflict_fwd: got %h want %h", out_xpos_ser, mk(8'h44, 9'd1, 64'd77)); end
    idle(); tick();
    n_checks++; if (out_xpos_ser !== mk(8'h03, 9'd5, 64'd42)) begin n_fail++; $display("FAIL conflict_res: got %h want %h", out_xpos_ser, mk(8'h03, 9'd5, 64'd42)); end
    tick();
    n_checks++; if (out_xpos_ser !== 82'd0) begin n_fail++; $display("FAIL conflict_after: got %h want 0", out_xpos_ser); end
  endtask

  task automatic test_priority();
    do_reset();
    program_comm(8'h02, SUM, 4'd1, 9'd3, 2'b11);
    inject_xpos = inj(1'b0, mk(8'h02, 9'd0, 64'd10));
    inject_ypos = inj(1'b1, mk(8'h66, 9'd2, 64'd99));
    in_ypos_ser = mk(8'h40, 9'd0, 64'd55);
    tick();
    n_checks++; if (out_xpos_ser !== mk(8'h02, 9'd3, 64'd10)) begin n_fail++; $display("FAIL prio_x: got %h want %h", out_xpos_ser, mk(8'h02, 9'd3, 64'd10)); end
    n_checks++; if (out_ypos_ser !== mk(8'h40, 9'd0, 64'd55)) begin n_fail++; $display("FAIL prio_y_fwd: got %h want %h", out_ypos_ser, mk(8'h40, 9'd0, 64'd55)); end
    idle(); tick();
    n_checks++; if (out_xpos_ser !== 82'd0) begin n_fail++; $display("FAIL prio_x_once: got %h want 0", out_xpos_ser); end
    n_checks++; if (out_ypos_ser !== mk(8'h02, 9'd3, 64'd10)) begin n_fail++; $display("FAIL prio_y_res: got %h want %h", out_ypos_ser, mk(8'h02, 9'd3, 64'd10)); end
    tick();
    n_checks++; if ({out_xpos_ser, out_ypos_ser} !== 164'd0) begin n_fail++; $display("FAIL prio_after: got %h %h want 0 0", out_xpos_ser, out_ypos_ser); end
  endtask

  task automatic test_bypass_and_drop();
    do_reset();
    program_comm(8'h01, SUM, 4'd1, 9'd1, 2'b10);
    inject_xpos = inj(1'b1, mk(8'h77, 9'd1, 64'd123));
    inject_ypos = inj(1'b1, mk(8'h01, 9'd0, 64'd5));
    tick();
    n_checks++; if (out_xpos_ser !== mk(8'h77, 9'd1, 64'd123)) begin n_fail++; $display("FAIL bypass_x: got %h want %h", out_xpos_ser, mk(8'h77, 9'd1, 64'd123)); end
    n_checks++; if (out_ypos_ser !== mk(8'h01, 9'd0, 64'd5)) begin n_fail++; $display("FAIL bypass_match_y: got %h want %h", out_ypos_ser, mk(8'h01, 9'd0, 64'd5)); end
    idle();
    inject_xpos = inj(1'b0, mk(8'h55, 9'd0, 64'd8));
    tick();
    n_checks++; if ({out_xpos_ser, out_ypos_ser} !== 164'd0) begin n_fail++; $display("FAIL inject_drop: got %h %h want 0 0", out_xpos_ser, out_ypos_ser); end
    idle();
    program_comm(8'h06, SUM, 4'd1, 9'd2, 2'b00);
    in_xpos_ser = mk(8'h06, 9'd0, 64'd31);
    tick(); idle(); tick();
    n_checks++; if ({out_xpos_ser, out_ypos_ser} !== 164'd0) begin n_fail++; $display("FAIL mask0: got %h %h want 0 0", out_xpos_ser, out_ypos_ser); end
    program_comm(8'h05, SUM, 4'd2, 9'd4, 2'b01);
    newcomm = nc(8'h05, SUM, 4'd2, 9'd4, 2'b01);
    in_xpos_ser = mk(8'h05, 9'd0, 64'd100);
    tick();
    n_checks++; if (out_xpos_ser !== 82'd0) begin n_fail++; $display("FAIL wr_prec_nofwd: got %h want 0", out_xpos_ser); end
    idle(); in_xpos_ser = mk(8'h05, 9'd0, 64'd1); tick();
    n_checks++; if (out_xpos_ser !== 82'd0) begin n_fail++; $display("FAIL wr_prec_discard: got %h want 0", out_xpos_ser); end
    in_xpos_ser = mk(8'h05, 9'd0, 64'd2); tick();
    n_checks++; if (out_xpos_ser !== mk(8'h05, 9'd4, 64'd3)) begin n_fail++; $display("FAIL wr_prec_res: got %h want %h", out_xpos_ser, mk(8'h05, 9'd4, 64'd3)); end
    idle(); tick();
  endtask

  task automatic test_min_wrap();
    do_reset();
    program_comm(8'h01, MIN, 4'd2, 9'd1, 2'b10);
    in_ypos_ser = mk(8'h01, 9'd0, ONES); tick();
    n_checks++; if (out_ypos_ser !== 82'd0) begin n_fail++; $display("FAIL min_partial: got %h want 0", out_ypos_ser); end
    in_ypos_ser = mk(8'h01, 9'd0, 64'd0); tick();
    n_checks++; if (out_ypos_ser !== mk(8'h01, 9'd1, 64'd0)) begin n_fail++; $display("FAIL min_res: got %h want %h", out_ypos_ser, mk(8'h01, 9'd1, 64'd0)); end
    idle();
    program_comm(8'h01, SUM, 4'd2, 9'd1, 2'b10);
    in_ypos_ser = mk(8'h01, 9'd0, ONES); tick();
    in_ypos_ser = mk(8'h01, 9'd0, 64'd0); tick();
    n_checks++; if (out_ypos_ser !== mk(8'h01, 9'd1, ONES)) begin n_fail++; $display("FAIL sum_ones: got %h want %h", out_ypos_ser, mk(8'h01, 9'd1, ONES)); end
    in_ypos_ser = mk(8'h01, 9'd0, ONES); tick();
    in_ypos_ser = mk(8'h01, 9'd0, 64'd2); tick();
    n_checks++; if (out_ypos_ser !== mk(8'h01, 9'd1, 64'd1)) begin n_fail++; $display("FAIL sum_wrap: got %h want %h", out_ypos_ser, mk(8'h01, 9'd1, 64'd1)); end
    idle(); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    program_comm(8'h01, SUM, 4'd3, 9'd2, 2'b01);
    in_xpos_ser = mk(8'h01, 9'd0, 64'd7);
    in_ypos_ser = mk(8'h22, 9'd0, 64'd8);
    tick(); idle();
    n_checks++; if (out_ypos_ser !== mk(8'h22, 9'd0, 64'd8)) begin n_fail++; $display("FAIL mid_fwd: got %h want %h", out_ypos_ser, mk(8'h22, 9'd0, 64'd8)); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (out_ypos_ser !== 82'd0) begin n_fail++; $display("FAIL mid_async_clear: got %h want 0", out_ypos_ser); end
    tick();
    rst = 1'b1;
    in_xpos_ser = mk(8'h01, 9'd0, 64'd1);
    tick();
    n_checks++; if (out_xpos_ser !== mk(8'h01, 9'd0, 64'd1)) begin n_fail++; $display("FAIL mid_table_cleared: got %h want %h", out_xpos_ser, mk(8'h01, 9'd0, 64'd1)); end
    idle();
    program_comm(8'h01, SUM, 4'd3, 9'd2, 2'b01);
    for (int i = 0; i < 3; i++) begin
      in_xpos_ser = mk(8'h01, 9'd0, 64'd1);
      tick();
    end
    n_checks++; if (out_xpos_ser !== mk(8'h01, 9'd2, 64'd3)) begin n_fail++; $display("FAIL mid_restart: got %h want %h", out_xpos_ser, mk(8'h01, 9'd2, 64'd3)); end
    idle(); tick();
  endtask

  task automatic test_random();
    logic [81:0] ex, ey;
    do_reset();
    model_clear();
    for (int i = 0; i < 1500; i++) begin
      inject_xpos = {1'($urandom_range(0, 1)), 2'($urandom), rflit()};
      inject_ypos = {1'($urandom_range(0, 1)), 2'($urandom), rflit()};
      in_xpos_ser = rflit();
      in_ypos_ser = rflit();
      if ($urandom_range(0, 7) == 0)
        newcomm = {1'b1, rcid(), 18'($urandom), 3'($urandom_range(0, 4)),
                   4'($urandom_range(0, 7)), 9'($urandom), 7'($urandom),
                   2'($urandom), 9'($urandom)};
      else
        newcomm = {1'b0, 60'({$urandom, $urandom})};
      model_step(ex, ey);
      tick();
      n_checks++; if (out_xpos_ser !== ex) begin n_fail++; $display("FAIL rand_x cyc %0d: got %h want %h", i, out_xpos_ser, ex); end
      n_checks++; if (out_ypos_ser !== ey) begin n_fail++; $display("FAIL rand_y cyc %0d: got %h want %h", i, out_ypos_ser, ey); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_sum();
    test_same_cycle();
    test_conflict();
    test_priority();
    test_bypass_and_drop();
    test_min_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
